conv_scheduler: RTL and testbench
=================================

# conv_scheduler

Sequencer for the 3x3 image-smoothing convolution. On a start pulse it latches a 72-bit kernel and walks every valid output pixel of an IMG_W x IMG_H image held in the pixel RAM. For each output pixel it issues 9 RAM reads and presents the matching 8-bit weight to the downstream MAC, with first/last tap markers and a ready-based stall. It replaces free-running address/weight generation with a bounded, restartable job that reports busy and done.

## Interface
- IMG_W, 16, image width in pixels (>=3)
- IMG_H, 16, image height in pixels (>=3)
- ADDR_W, 8, pixel RAM address width; IMG_W*IMG_H <= 2**ADDR_W
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; low forces all state and outputs to reset values
- start  in  1  job request, sampled in IDLE only
- kernel  in  72  nine 8-bit weights, tap k at kernel[71-8k -: 8]; latched on accepted start
- tap_ready  in  1  MAC can take a tap issued this cycle
- ram_en  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM read address
- weight  out  8  weight aligned with RAM read data
- tap_valid  out  1  RAM data and weight valid this cycle
- tap_first  out  1  first tap (k=0) of an output pixel
- tap_last  out  1  last tap (k=8) of an output pixel
- out_addr  out  ADDR_W  output pixel index y*(IMG_W-2)+x, valid with tap_last
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches kernel, clears x, y, k, and moves to RUN. start in any other state is ignored.
- RUN: an issue occurs when tap_ready=1. Each issue drives ram_en=1 and ram_addr=(y+r)*IMG_W+(x+c), where r=k/3 and c=k%3.
- No issue when tap_ready=0: ram_en=0 and all counters hold.
- Tap order is row-major, k=0..8. k wraps to 0 and advances x; x wraps at IMG_W-3 and advances y.
- After the issue with k=8, x=IMG_W-3, y=IMG_H-3, the FSM moves to DRAIN.
- DRAIN lasts one cycle and emits the final tap. The FSM then goes to DONE, pulses done for one cycle, and returns to IDLE.
- Pipeline stage: weight, tap_valid, tap_first, tap_last and out_addr are registered copies of the issue cycle, matching the RAM's 1-cycle read latency.
- The consumer must accept every tap_valid. tap_ready only gates new issues.
- Address arithmetic is computed at ADDR_W+2 bits and truncated to ADDR_W; no overflow is possible within the legal parameter range.
- Reset values: ram_en=0, ram_addr=0, weight=0, tap_valid=0, tap_first=0, tap_last=0, out_addr=0, busy=0, done=0. State returns to IDLE.
- Reset asserted mid-job aborts the job immediately. No done is produced, and a new start is required.

## Timing
- Start sampled at edge 0 -> RUN from cycle 1. First ram_en=1 in cycle 1 if tap_ready=1.
- busy=1 from cycle 1 through DRAIN inclusive, and 0 in DONE.
- Issue at cycle t -> tap_valid/weight at cycle t+1.
- Unstalled job length: 9*(IMG_W-2)*(IMG_H-2) issues, which is 1764 for 16x16.
  - Last issue in cycle 1764.
  - Final tap_last in cycle 1765 (DRAIN).
  - done in cycle 1766.
- Each stall cycle delays all later events by exactly one cycle.
- Start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.

## Configuration
- CONV_SCHED_STALL_CNT_EN defined: adds output stall_cnt[15:0].
  - Counts RUN cycles with tap_ready=0.
  - Cleared on accepted start, saturates at 16'hFFFF.
  - Holds its value after done; resets to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package conv_pkg holds:
  - state encoding (IDLE, RUN, DRAIN, DONE)
  - TAPS=9, KERNEL_W=72, WEIGHT_W=8
  - the tap-to-(r,c) mapping constants
- One sub-module, conv_addr_gen: combinational x/y/k -> ram_addr and out_addr computation. It is reused by a later writeback controller.

## Test plan
- Reset, then start with kernel=72'h010203040506070809 and tap_ready=1:
  - first issue addresses are 0,1,2,16,17,18,32,33,34
  - weights arrive one cycle later as 01..09
  - tap_first occurs with 01, tap_last with 09, out_addr=0
- Full unstalled 16x16 job: exactly 1764 tap_valid and 196 tap_last; last ram_addr=255, last out_addr=195; done at cycle 1766; busy low only in DONE/IDLE.
- tap_ready low for 5 cycles mid-pixel: no ram_en during the stall, addresses resume unchanged, done delayed by exactly 5 cycles, and stall_cnt=5 when the macro is defined.
- start pulsed again while busy and in DONE: ignored, with no kernel change and no extra done.
- reset driven low at cycle 100 of a job: all outputs 0 in the same cycle, no done. A new start then produces a full, correct job with first address 0.
- Row wrap: the tap after out_addr=13 completes (x=13, y=0) is at address 16 (x=0, y=1).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution scheduler and its address generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int TAPS     = 9;
  localparam int KERNEL_W = 72;
  localparam int WEIGHT_W = 8;
  localparam int TAP_W    = 4;

  // Tap k -> window row r = k/3 and column c = k%3, packed two bits per tap,
  // tap 0 in the least significant pair.
  localparam logic [2*TAPS-1:0] TAP_ROW_LUT =
    {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [2*TAPS-1:0] TAP_COL_LUT =
    {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

  function automatic logic [1:0] tap_row(input logic [TAP_W-1:0] k);
    return TAP_ROW_LUT[2*k +: 2];
  endfunction

  function automatic logic [1:0] tap_col(input logic [TAP_W-1:0] k);
    return TAP_COL_LUT[2*k +: 2];
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Maps window position (x, y) and tap index k to a pixel RAM read address and output pixel index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   x, y      window top-left corner (output pixel coordinates)
//   k         tap index 0..8, row-major inside the 3x3 window
//   ram_addr  (y + k/3) * IMG_W + (x + k%3)
//   out_addr  y * (IMG_W - 2) + x
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] x,
  input  logic [ADDR_W-1:0] y,
  input  logic [TAP_W-1:0]  k,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W-1:0] out_addr
);

  // Two guard bits so the intermediate sums cannot wrap before truncation.
  localparam int AW = ADDR_W + 2;

  logic [AW-1:0] row;
  logic [AW-1:0] col;

  always_comb begin
    row      = AW'(y) + AW'(tap_row(k));
    col      = AW'(x) + AW'(tap_col(k));
    ram_addr = ADDR_W'(row * AW'(IMG_W) + col);
    out_addr = ADDR_W'(AW'(y) * AW'(IMG_W - 2) + AW'(x));
  end

endmodule

// File: rtl/conv_scheduler.sv
// Job sequencer for the 3x3 smoothing convolution: walks every valid output pixel, 9 RAM reads each.
// Latency: ram_en/ram_addr in the issue cycle; weight/tap_* /out_addr one cycle later (RAM read latency).
// Backpressure: tap_ready=0 suppresses the issue and freezes all counters; issued taps are never stalled.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-low reset
//   start, kernel   job request (IDLE only) and nine 8-bit weights, tap k at kernel[71-8k -: 8]
//   tap_ready       consumer can take a tap issued this cycle
//   ram_en/ram_addr pixel RAM read strobe and address
//   weight, tap_valid, tap_first, tap_last, out_addr   registered tap stream to the MAC
//   busy, done      job in progress (RUN/DRAIN); one-cycle end-of-job pulse
//   stall_cnt       present only with CONV_SCHED_STALL_CNT_EN: saturating count of stalled RUN cycles
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KERNEL_W-1:0] kernel,
  input  logic                tap_ready,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [WEIGHT_W-1:0] weight,
  output logic                tap_valid,
  output logic                tap_first,
  output logic                tap_last,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                busy,
  output logic                done
`ifdef CONV_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 3);
  localparam logic [TAP_W-1:0]  K_LAST = TAP_W'(TAPS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   x_q;
  logic [ADDR_W-1:0]   y_q;
  logic [TAP_W-1:0]    k_q;
  logic [WEIGHT_W-1:0] kern_q [TAPS];
  logic [ADDR_W-1:0]   pix_addr;
  logic                accept;
  logic                issue;
  logic                last_issue;

  assign accept     = (state_q == ST_IDLE) && start;
  assign issue      = (state_q == ST_RUN) && tap_ready;
  assign last_issue = issue && (k_q == K_LAST) && (x_q == X_LAST) && (y_q == Y_LAST);
  assign ram_en     = issue;

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .x        (x_q),
    .y        (y_q),
    .k        (k_q),
    .ram_addr (ram_addr),
    .out_addr (pix_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Final tap is on the registered outputs this cycle.
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window walk: k fastest, then x, then y. The last issue wraps everything
  // to zero so ram_addr rests at 0 between jobs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      x_q <= '0;
      y_q <= '0;
      k_q <= '0;
    end else if (issue) begin
      if (k_q == K_LAST) begin
        k_q <= '0;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) kern_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < TAPS; i++) kern_q[i] <= kernel[KERNEL_W-1-WEIGHT_W*i -: WEIGHT_W];
    end
  end

  // One-cycle delay so the tap descriptor lines up with the RAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight    <= '0;
      tap_valid <= 1'b0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      out_addr  <= '0;
    end else begin
      tap_valid <= issue;
      tap_first <= issue && (k_q == '0);
      tap_last  <= issue && (k_q == K_LAST);
      if (issue) begin
        weight   <= kern_q[k_q];
        out_addr <= pix_addr;
      end
    end
  end

`ifdef CONV_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if ((state_q == ST_RUN) && !tap_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_scheduler.sv
module tb_conv_scheduler;

  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int ADDR_W = 8;
  localparam int JOB_DONE = 1766;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [71:0]       kernel = '0;
  logic              tap_ready = 1'b0;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        weight;
  logic              tap_valid;
  logic              tap_first;
  logic              tap_last;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  conv_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .kernel    (kernel),
    .tap_ready (tap_ready),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .weight    (weight),
    .tap_valid (tap_valid),
    .tap_first (tap_first),
    .tap_last  (tap_last),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] w;
    logic       first;
    logic       last;
    logic [7:0] oa;
  } tap_t;

  tap_t       exp_tap_q[$];
  logic [7:0] exp_addr_q[$];
  int         exp_done_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int job_c0 = 0;

  // Observations gathered by the monitor for the current job.
  int         issue_idx, n_valid, n_last, n_done;
  logic [7:0] first_addrs [9];
  logic [7:0] wrap_addr, last_addr, last_oa;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation whenever the DUT presents something.
  always @(negedge clk) begin
    int   rel;
    tap_t et, at;
    rel = cyc - job_c0;
    if (ram_en) begin
      check("ram_en_only_when_ready", tap_ready, 1'b1);
      if (exp_addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ram_en: addr %0d with nothing expected", ram_addr);
      end else begin
        check("ram_addr", ram_addr, exp_addr_q.pop_front());
      end
      if (issue_idx < 9) first_addrs[issue_idx] = ram_addr;
      if (issue_idx == 126) wrap_addr = ram_addr;
      last_addr = ram_addr;
      issue_idx++;
    end
    if (tap_valid) begin
      n_valid++;
      if (tap_last) begin
        n_last++;
        last_oa = out_addr;
      end
      if (exp_tap_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_tap: weight %0h with nothing expected", weight);
      end else begin
        et = exp_tap_q.pop_front();
        at.w     = weight;
        at.first = tap_first;
        at.last  = tap_last;
        at.oa    = et.last ? out_addr : 8'h00;
        check("tap{w,first,last,out_addr}", at, et);
      end
    end
    if (done) begin
      n_done++;
      check("busy_low_in_done", busy, 1'b0);
      if (exp_done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: at rel cycle %0d", rel);
      end else begin
        check("done_cycle", rel, exp_done_q.pop_front());
      end
    end
  end

  // One job. stall_len cycles of tap_ready=0 from cycle stall_from; poke pulses
  // start mid-job and in the DONE cycle; abort_at>=0 pulls reset in that cycle.
  task automatic run_job(input logic [71:0] kv, input int stall_from, input int stall_len,
                         input bit poke, input int abort_at);
    int rel;
    int dcyc;
    int limit;
    dcyc  = JOB_DONE + stall_len;
    limit = dcyc + 12;
    for (int y = 0; y < IMG_H - 2; y++)
      for (int x = 0; x < IMG_W - 2; x++)
        for (int k = 0; k < 9; k++) begin
          tap_t t;
          exp_addr_q.push_back(8'((y + k / 3) * IMG_W + x + k % 3));
          t.w     = kv[71 - 8*k -: 8];
          t.first = (k == 0);
          t.last  = (k == 8);
          t.oa    = (k == 8) ? 8'(y * (IMG_W - 2) + x) : 8'h00;
          exp_tap_q.push_back(t);
        end
    exp_done_q.push_back(dcyc);
    issue_idx = 0; n_valid = 0; n_last = 0; n_done = 0;
    @(posedge clk); #1;
    check("busy_idle_before_start", busy, 1'b0);
    start = 1'b1; kernel = kv; tap_ready = 1'b1; job_c0 = cyc;
    for (int g = 0; g < limit + 4; g++) begin
      @(posedge clk); #1;
      rel = cyc - job_c0;
      if (rel >= limit) break;
      if (rel == 1) begin
        start = 1'b0;
        check("busy_in_run", busy, 1'b1);
      end
      tap_ready = !(rel >= stall_from && rel < stall_from + stall_len);
      if (poke && (rel == 50 || rel == dcyc)) begin
        start = 1'b1; kernel = ~kv;
      end
      if (poke && (rel == 51 || rel == dcyc + 1)) start = 1'b0;
      if (rel == abort_at) begin
        reset = 1'b0;
        #1;
        check("outputs_zero_on_reset",
              {ram_en, ram_addr, weight, tap_valid, tap_first, tap_last, out_addr, busy, done},
              '0);
        exp_addr_q.delete(); exp_tap_q.delete(); exp_done_q.delete();
        break;
      end
    end
    if (abort_at >= 0) begin
      repeat (5) @(posedge clk);
      #1;
      check("no_done_after_abort", n_done, 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_abort", busy, 1'b0);
    end else begin
      check("done_count", n_done, 1);
      check("tap_valid_count", n_valid, 1764);
      check("tap_last_count", n_last, 196);
      check("last_ram_addr", last_addr, 8'd255);
      check("last_out_addr", last_oa, 8'd195);
      check("first_ram_addr", first_addrs[0], 8'd0);
      check("addr_q_drained", exp_addr_q.size(), 0);
      check("tap_q_drained", exp_tap_q.size(), 0);
      check("done_q_drained", exp_done_q.size(), 0);
`ifdef CONV_SCHED_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall_len);
`endif
    end
  endtask

  initial begin
    logic [7:0] first_tab [9];
    first_tab = '{8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {ram_en, ram_addr, weight, tap_valid, tap_first, tap_last, out_addr, busy, done}, '0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Unstalled job with the reference kernel.
    run_job(72'h010203040506070809, 0, 0, 1'b0, -1);
    for (int i = 0; i < 9; i++) check($sformatf("first_pixel_addr[%0d]", i), first_addrs[i], first_tab[i]);
    check("row_wrap_addr", wrap_addr, 8'd16);

    // Five-cycle stall mid-pixel plus ignored start pulses (RUN and DONE).
    run_job(72'h112233445566778899, 5, 5, 1'b1, -1);

    // Abort by reset in cycle 100, then a clean full job.
    run_job(72'hA1B2C3D4E5F6071829, 0, 0, 1'b0, 100);
    run_job(72'h0F1E2D3C4B5A697887, 0, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
